spi_slave_param: RTL and testbench
==================================

# spi_slave_param

Parametrised SPI slave front-end for the SPI-to-RAM interface. It deserialises MOSI frames of a 2-bit command plus a `PAYLOAD_W`-bit payload, and presents each completed frame to the memory side as a single-cycle `rx_valid` word. For read-data commands it serialises the returned word on MISO under a `tx_valid` handshake. Compared with the fixed 8-bit slave, it adds a configurable payload width and bit order, explicit read-address tracking, mid-frame abort detection and a protocol-error flag.

## Interface
Parameters:
- `PAYLOAD_W`, default 8: payload bits per frame; legal range is 4–32.
- `LSB_FIRST`, default 0: 1 sends and receives the payload LSB-first; the command bits are always sent first, MSB-first.

Ports:
- `clk`  in  1  the single clock; SPI bits are sampled on every rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `SS_n`  in  1  slave select, active low.
- `MOSI`  in  1  serial data in.
- `MISO`  out  1  serial data out; 0 when not sending.
- `rx_data`  out  PAYLOAD_W+2  {cmd[1:0], payload}, with the payload always in natural bit order.
- `rx_valid`  out  1  one-cycle strobe marking `rx_data` valid.
- `tx_data`  in  PAYLOAD_W  read data to return.
- `tx_valid`  in  1  `tx_data` valid; sampled only in WAIT_TX.
- `frame_err`  out  1  one-cycle strobe on abort or protocol error.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Commands: 00 = write address, 01 = write data, 10 = read address, 11 = read data.
- States: IDLE, CMD, RECV, WAIT_TX, SEND, HOLD.
- IDLE → CMD when `SS_n` is sampled low. No bit is captured on this edge.
- CMD: sample `cmd[1]`, then go to RECV.
- RECV: sample `cmd[0]`, then `PAYLOAD_W` payload bits, one per edge.
- On the edge that samples the last bit, register `rx_data` and the command. Then branch on the command:
  - 00, 01 or 10 → assert `rx_valid`, go to HOLD.
  - 11 with `rd_addr_pending` = 1 → assert `rx_valid`, go to WAIT_TX.
  - 11 with `rd_addr_pending` = 0 → do not assert `rx_valid`; pulse `frame_err`, go to HOLD.
- `rd_addr_pending` is set by an accepted cmd 10 frame and cleared by an accepted cmd 11 frame.
- WAIT_TX: hold until `tx_valid` is sampled high. On that edge, load `tx_data` into the shift register, drive the first payload bit on MISO and go to SEND.
- SEND: drive one bit per edge until `PAYLOAD_W` bits are out. On the next edge, set MISO to 0 and go to HOLD.
- HOLD: ignore MOSI; go to IDLE when `SS_n` is high.
- Abort: `SS_n` sampled high in CMD, RECV, WAIT_TX or SEND gives:
  - next state IDLE;
  - MISO 0 and counter 0;
  - no `rx_valid`;
  - `frame_err` pulsed for one cycle;
  - `rd_addr_pending` unchanged.
- `SS_n` high in HOLD is a normal end of frame and produces no error.

## Timing
- Reset values: state IDLE; `MISO`, `rx_valid`, `frame_err` and `rd_addr_pending` all 0; `rx_data` 0; counter and shift registers 0.
- Reset is asynchronous. Asserting it mid-frame returns everything to the reset values immediately, with no `frame_err`.
- Frame timing: edge 0 sees `SS_n` low. MOSI bits are sampled on edges 1 .. PAYLOAD_W+2. `rx_valid` is high for the cycle after edge PAYLOAD_W+2 (cycle 11 for PAYLOAD_W=8).
- `rx_data` holds its value until the next accepted frame.
- Read return: with `tx_valid` sampled at edge k, MISO carries payload bit i during the cycle after edge k+i, for i = 0 .. PAYLOAD_W−1. MISO is 0 after edge k+PAYLOAD_W.
- `tx_valid` may be high as early as the edge that ends RECV, but is honoured only from WAIT_TX onward; earlier assertions are ignored.
- The bit counter is $clog2(PAYLOAD_W+2) bits wide and resets to 0 on every state change.
- `busy` is combinational from the state.

## Structure
- Package `spi_slave_pkg`:
  - state enum, one-hot encoded;
  - command codes `CMD_WR_ADDR`, `CMD_WR_DATA`, `CMD_RD_ADDR`, `CMD_RD_DATA`.
- Sub-module `spi_bit_shifter`: a parametrised bidirectional shift register with load, shift-in and shift-out, and LSB/MSB selection. It is instantiated twice, once for RX and once for TX.
- The FSM, counter and `rd_addr_pending` live in the top module.

## Test plan
- PAYLOAD_W=8, write frame 00 + 0xA5 → `rx_valid` in cycle 11 with `rx_data` = 10'h0A5; MISO stays 0 throughout.
- Read-address frame 10 + 0x3C, then read-data frame 11 + 0x00 with `tx_valid`/`tx_data` = 0x96 two cycles after `rx_valid` → MISO serialises 1,0,0,1,0,1,1,0; `rd_addr_pending` returns to 0.
- Read-data frame 11 with no prior read address → `frame_err` pulses once, no `rx_valid`, MISO stays 0.
- `SS_n` raised after 5 bits of a write frame → `frame_err` pulses once, next state IDLE, no `rx_valid`; a following clean frame decodes correctly.
- LSB_FIRST=1, PAYLOAD_W=12, write frame 01 + 0xABC sent LSB-first → `rx_data` = 14'h1ABC; read of 0x5A3 emits bits LSB-first.
- `rst_n` pulsed low during SEND → MISO drops to 0 without waiting for `clk`; state IDLE; no `frame_err`.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared definitions for the parametrised SPI slave front-end.
// Holds the one-hot FSM state encoding and the 2-bit command codes.
package spi_slave_pkg;

  // One-hot FSM states.
  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_CMD     = 6'b000010,
    ST_RECV    = 6'b000100,
    ST_WAIT_TX = 6'b001000,
    ST_SEND    = 6'b010000,
    ST_HOLD    = 6'b100000
  } state_t;

  // Frame command codes (first two MOSI bits, MSB first).
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_param_if.sv
// Bus bundle between the SPI/memory side and the SPI slave front-end.
// Signals: SS_n, MOSI, MISO (serial side); rx_data/rx_valid (received word);
// tx_data/tx_valid (read return); frame_err, busy (status).
// The slave modport is the front-end; master is whoever drives it.
interface spi_slave_param_if #(
  parameter int PAYLOAD_W = 8
) ();

  logic                 SS_n;
  logic                 MOSI;
  logic                 MISO;
  logic [PAYLOAD_W+1:0] rx_data;
  logic                 rx_valid;
  logic [PAYLOAD_W-1:0] tx_data;
  logic                 tx_valid;
  logic                 frame_err;
  logic                 busy;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, frame_err, busy
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, frame_err, busy
  );

endinterface

// File: rtl/spi_bit_shifter.sv
// Parametrised bidirectional shift register with synchronous clear,
// parallel load and serial shift-in.
// Ports: clr/load/shift controls (priority in that order), load_data,
// ser_in; par_next is the value the register takes on the next edge and
// ser_next is the bit at the output end of that value (bit 0 when
// LSB_FIRST, else bit W-1). Exposing the next value lets the caller
// capture a word and drive its first bit on the same edge as the shift/load.
module spi_bit_shifter #(
  parameter int W         = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift,
  input  logic         ser_in,
  output logic [W-1:0] par_next,
  output logic         ser_next
);

  logic [W-1:0] q_r;

  // Next register value; LSB-first shifts right so the first bit ends at bit 0.
  always_comb begin
    par_next = q_r;
    if (clr) begin
      par_next = {W{1'b0}};
    end else if (load) begin
      par_next = load_data;
    end else if (shift) begin
      if (LSB_FIRST) begin
        par_next = {ser_in, q_r[W-1:1]};
      end else begin
        par_next = {q_r[W-2:0], ser_in};
      end
    end else begin
      par_next = q_r;
    end
  end

  // Output-end bit of the next value.
  always_comb begin
    ser_next = 1'b0;
    if (LSB_FIRST) begin
      ser_next = par_next[0];
    end else begin
      ser_next = par_next[W-1];
    end
  end

  // Shift register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= {W{1'b0}};
    end else begin
      q_r <= par_next;
    end
  end

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave front-end (top).
// Ports: clk, rst_n (async active-low), bus (slave modport): deserialises
// {cmd[1:0], payload} frames from MOSI into rx_data/rx_valid, returns
// read data on MISO after a tx_valid handshake, flags aborts and reads
// without a preceding read address on frame_err; busy = state != IDLE.
// PAYLOAD_W legal range 4..32; LSB_FIRST applies to the payload only.
module spi_slave_param
  import spi_slave_pkg::*;
#(
  parameter int PAYLOAD_W = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_slave_param_if.slave bus
);

  localparam int                 CNT_W       = $clog2(PAYLOAD_W + 2);
  localparam logic [CNT_W-1:0]   CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST_RX = CNT_W'(PAYLOAD_W);
  localparam logic [CNT_W-1:0]   CNT_LAST_TX = CNT_W'(PAYLOAD_W - 1);

  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [1:0]             cmd_r;
  logic                   rd_addr_pending_r;
  logic [PAYLOAD_W+1:0]   rx_data_r;
  logic                   rx_valid_r;
  logic                   frame_err_r;
  logic                   miso_r;

  logic                   abort_s;
  logic                   rx_shift_s;
  logic                   tx_load_s;
  logic                   tx_shift_s;
  logic [PAYLOAD_W-1:0]   rx_word_s;
  logic                   rx_ser_unused_s;
  logic [PAYLOAD_W-1:0]   tx_word_unused_s;
  logic                   tx_ser_s;

  // Shifter controls; SS_n high mid-frame overrides everything as an abort.
  always_comb begin
    abort_s    = 1'b0;
    rx_shift_s = 1'b0;
    tx_load_s  = 1'b0;
    tx_shift_s = 1'b0;
    unique case (state_r)
      ST_CMD: begin
        abort_s = bus.SS_n;
      end
      ST_RECV: begin
        if (bus.SS_n) begin
          abort_s = 1'b1;
        end else begin
          // count 0 is cmd[0]; payload bits occupy counts 1..PAYLOAD_W
          rx_shift_s = (cnt_r != CNT_ZERO);
        end
      end
      ST_WAIT_TX: begin
        if (bus.SS_n) begin
          abort_s = 1'b1;
        end else begin
          tx_load_s = bus.tx_valid;
        end
      end
      ST_SEND: begin
        if (bus.SS_n) begin
          abort_s = 1'b1;
        end else begin
          tx_shift_s = (cnt_r != CNT_LAST_TX);
        end
      end
      default: begin
        abort_s = 1'b0;
      end
    endcase
  end

  spi_bit_shifter #(.W(PAYLOAD_W), .LSB_FIRST(LSB_FIRST)) u_rx_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (abort_s),
    .load     (1'b0),
    .load_data({PAYLOAD_W{1'b0}}),
    .shift    (rx_shift_s),
    .ser_in   (bus.MOSI),
    .par_next (rx_word_s),
    .ser_next (rx_ser_unused_s)
  );

  spi_bit_shifter #(.W(PAYLOAD_W), .LSB_FIRST(LSB_FIRST)) u_tx_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (abort_s),
    .load     (tx_load_s),
    .load_data(bus.tx_data),
    .shift    (tx_shift_s),
    .ser_in   (1'b0),
    .par_next (tx_word_unused_s),
    .ser_next (tx_ser_s)
  );

  // Frame FSM with counter, read-address tracking and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= ST_IDLE;
      cnt_r             <= CNT_ZERO;
      cmd_r             <= 2'b00;
      rd_addr_pending_r <= 1'b0;
      rx_data_r         <= {(PAYLOAD_W + 2){1'b0}};
      rx_valid_r        <= 1'b0;
      frame_err_r       <= 1'b0;
      miso_r            <= 1'b0;
    end else begin
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      if (abort_s) begin
        state_r     <= ST_IDLE;
        cnt_r       <= CNT_ZERO;
        miso_r      <= 1'b0;
        frame_err_r <= 1'b1;
      end else begin
        unique case (state_r)
          ST_IDLE: begin
            miso_r <= 1'b0;
            cnt_r  <= CNT_ZERO;
            if (!bus.SS_n) begin
              state_r <= ST_CMD;
            end
          end
          ST_CMD: begin
            cmd_r[1] <= bus.MOSI;
            cnt_r    <= CNT_ZERO;
            state_r  <= ST_RECV;
          end
          ST_RECV: begin
            if (cnt_r == CNT_ZERO) begin
              cmd_r[0] <= bus.MOSI;
              cnt_r    <= CNT_ONE;
            end else if (cnt_r != CNT_LAST_RX) begin
              cnt_r <= cnt_r + CNT_ONE;
            end else begin
              cnt_r <= CNT_ZERO;
              if ((cmd_r == CMD_RD_DATA) && !rd_addr_pending_r) begin
                // read data with no address: reject, rx_data keeps old word
                frame_err_r <= 1'b1;
                state_r     <= ST_HOLD;
              end else begin
                rx_data_r  <= {cmd_r, rx_word_s};
                rx_valid_r <= 1'b1;
                if (cmd_r == CMD_RD_DATA) begin
                  rd_addr_pending_r <= 1'b0;
                  state_r           <= ST_WAIT_TX;
                end else begin
                  if (cmd_r == CMD_RD_ADDR) begin
                    rd_addr_pending_r <= 1'b1;
                  end
                  state_r <= ST_HOLD;
                end
              end
            end
          end
          ST_WAIT_TX: begin
            cnt_r <= CNT_ZERO;
            if (bus.tx_valid) begin
              miso_r  <= tx_ser_s;
              state_r <= ST_SEND;
            end
          end
          ST_SEND: begin
            if (cnt_r == CNT_LAST_TX) begin
              miso_r  <= 1'b0;
              cnt_r   <= CNT_ZERO;
              state_r <= ST_HOLD;
            end else begin
              miso_r <= tx_ser_s;
              cnt_r  <= cnt_r + CNT_ONE;
            end
          end
          ST_HOLD: begin
            miso_r <= 1'b0;
            cnt_r  <= CNT_ZERO;
            if (bus.SS_n) begin
              state_r <= ST_IDLE;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            miso_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.MISO      = miso_r;
  assign bus.rx_data   = rx_data_r;
  assign bus.rx_valid  = rx_valid_r;
  assign bus.frame_err = frame_err_r;
  assign bus.busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_param.sv
// Self-checking bench: two DUTs (8-bit MSB-first, 12-bit LSB-first).
// Driver tasks push expected rx words, frame errors and MISO returns into
// queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_spi_slave_param;

  typedef struct { int d; int c; logic [33:0] w; } rx_t;
  typedef struct { int d; int c; } err_t;
  typedef struct { int d; int k; logic [31:0] w; } tx_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ss_n [2];
  logic        mosi [2];
  logic        txv [2];
  logic [31:0] txd [2];
  logic        miso [2];
  logic        rxv [2];
  logic [33:0] rxd [2];
  logic        ferr [2];
  logic        busy [2];

  int wid [2] = '{8, 12};
  bit lsbf [2] = '{1'b0, 1'b1};
  bit pend [2] = '{1'b0, 1'b0};

  int cyc = 0;
  int total = 0;
  int bad = 0;

  rx_t  exp_rx [$];
  err_t exp_err [$];
  tx_t  exp_tx [$];

  spi_slave_param_if #(.PAYLOAD_W(8))  bus0 ();
  spi_slave_param_if #(.PAYLOAD_W(12)) bus1 ();

  assign bus0.SS_n     = ss_n[0];
  assign bus0.MOSI     = mosi[0];
  assign bus0.tx_valid = txv[0];
  assign bus0.tx_data  = txd[0][7:0];
  assign bus1.SS_n     = ss_n[1];
  assign bus1.MOSI     = mosi[1];
  assign bus1.tx_valid = txv[1];
  assign bus1.tx_data  = txd[1][11:0];

  assign miso[0] = bus0.MISO;
  assign rxv[0]  = bus0.rx_valid;
  assign rxd[0]  = {24'd0, bus0.rx_data};
  assign ferr[0] = bus0.frame_err;
  assign busy[0] = bus0.busy;
  assign miso[1] = bus1.MISO;
  assign rxv[1]  = bus1.rx_valid;
  assign rxd[1]  = {20'd0, bus1.rx_data};
  assign ferr[1] = bus1.frame_err;
  assign busy[1] = bus1.busy;

  spi_slave_param #(.PAYLOAD_W(8), .LSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  spi_slave_param #(.PAYLOAD_W(12), .LSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Monitor: compares each presented output against the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (rxv[d]) begin
          if (exp_rx.size() == 0) begin
            chk("rx_valid_unexpected", 34'(rxv[d]), 34'd0);
          end else begin
            rx_t e;
            e = exp_rx.pop_front();
            chk("rx_dut", 34'(d), 34'(e.d));
            chk("rx_cycle", 34'(cyc), 34'(e.c));
            chk("rx_data", rxd[d], e.w);
          end
        end
        if (ferr[d]) begin
          if (exp_err.size() == 0) begin
            chk("frame_err_unexpected", 34'(ferr[d]), 34'd0);
          end else begin
            err_t e;
            e = exp_err.pop_front();
            chk("err_dut", 34'(d), 34'(e.d));
            chk("err_cycle", 34'(cyc), 34'(e.c));
          end
        end
        begin
          logic expv;
          bit   done;
          expv = 1'b0;
          done = 1'b0;
          if (exp_tx.size() > 0 && exp_tx[0].d == d) begin
            tx_t t;
            int  i;
            t = exp_tx[0];
            i = cyc - 1 - t.k;
            if (i >= 0 && i < wid[d]) expv = lsbf[d] ? t.w[i] : t.w[wid[d] - 1 - i];
            if (i >= wid[d]) done = 1'b1;
          end
          chk("miso", 34'(miso[d]), 34'(expv));
          if (done) void'(exp_tx.pop_front());
        end
      end
    end
  end

  // One frame on DUT d. abort_at >= 0 raises SS_n instead of sending bit abort_at.
  task automatic frame(input int d, input logic [1:0] cmd, input logic [31:0] pay,
                       input int abort_at, input int td, input bit early,
                       input logic [31:0] txw, input bit rst_mid);
    int          w;
    int          base;
    int          k;
    logic [33:0] seq;
    bit          is_read;
    bit          reject;
    w = wid[d];
    pay = pay & ((32'd1 << w) - 32'd1);
    txw = txw & ((32'd1 << w) - 32'd1);
    seq = 34'd0;
    seq[0] = cmd[1];
    seq[1] = cmd[0];
    for (int j = 0; j < w; j++) seq[2 + j] = lsbf[d] ? pay[j] : pay[w - 1 - j];
    is_read = (cmd == 2'b11) && pend[d] && (abort_at < 0);
    reject  = (cmd == 2'b11) && !pend[d] && (abort_at < 0);
    @(negedge clk);
    base = cyc;
    k = base + w + 2 + (early ? 1 : td);
    if (abort_at >= 0) begin
      exp_err.push_back('{d, base + abort_at + 2});
    end else if (reject) begin
      exp_err.push_back('{d, base + w + 3});
    end else begin
      exp_rx.push_back('{d, base + w + 3, (34'(cmd) << w) | 34'(pay)});
      if (cmd == 2'b10) pend[d] = 1'b1;
      if (cmd == 2'b11) pend[d] = 1'b0;
    end
    if (is_read) exp_tx.push_back('{d, k, txw});
    ss_n[d] = 1'b0;
    @(negedge clk);
    chk("busy_in_frame", 34'(busy[d]), 34'd1);
    for (int i = 0; i < w + 2; i++) begin
      if (i == abort_at) begin
        ss_n[d] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("busy_after_abort", 34'(busy[d]), 34'd0);
        return;
      end
      mosi[d] = seq[i];
      if (early && is_read && i == w + 1) begin
        txv[d] = 1'b1;
        txd[d] = txw;
      end
      @(negedge clk);
    end
    mosi[d] = 1'(($urandom));
    if (is_read) begin
      if (!early) begin
        repeat (td - 1) @(negedge clk);
        txv[d] = 1'b1;
        txd[d] = txw;
      end
      @(negedge clk);
      txv[d] = 1'b0;
      txd[d] = $urandom;
      if (rst_mid) begin
        repeat (2) @(negedge clk);
        chk("pre_rst_miso", 34'(miso[d]), 34'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_miso_async", 34'(miso[d]), 34'd0);
        chk("rst_busy_async", 34'(busy[d]), 34'd0);
        exp_tx.delete();
        ss_n[d] = 1'b1;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      repeat (w) @(negedge clk);
    end else begin
      @(negedge clk);
    end
    ss_n[d] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("busy_idle", 34'(busy[d]), 34'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      ss_n[d] = 1'b1;
      mosi[d] = 1'b0;
      txv[d]  = 1'b0;
      txd[d]  = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_miso", 34'(miso[d]), 34'd0);
      chk("reset_rx_valid", 34'(rxv[d]), 34'd0);
      chk("reset_frame_err", 34'(ferr[d]), 34'd0);
      chk("reset_busy", 34'(busy[d]), 34'd0);
      chk("reset_rx_data", rxd[d], 34'd0);
    end
    #2 rst_n = 1'b1;

    // write 00 + A5, then address/read return of 0x96
    frame(0, 2'b00, 32'hA5, -1, 1, 1'b0, 32'd0, 1'b0);
    frame(0, 2'b10, 32'h3C, -1, 1, 1'b0, 32'd0, 1'b0);
    frame(0, 2'b11, 32'h00, -1, 3, 1'b0, 32'h96, 1'b0);
    // pending consumed: next read-data is rejected
    frame(0, 2'b11, 32'h55, -1, 1, 1'b0, 32'hFF, 1'b0);
    // abort after 5 bits, then a clean frame
    frame(0, 2'b01, 32'h77, 5, 1, 1'b0, 32'd0, 1'b0);
    frame(0, 2'b01, 32'hC3, -1, 1, 1'b0, 32'd0, 1'b0);
    // abort in CMD and on the last bit; pending survives an abort
    frame(0, 2'b10, 32'h11, -1, 1, 1'b0, 32'd0, 1'b0);
    frame(0, 2'b00, 32'h22, 0, 1, 1'b0, 32'd0, 1'b0);
    frame(0, 2'b11, 32'h33, 9, 1, 1'b0, 32'd0, 1'b0);
    frame(0, 2'b11, 32'h44, -1, 1, 1'b1, 32'h5A, 1'b0);
    // 12-bit LSB-first DUT
    frame(1, 2'b01, 32'hABC, -1, 1, 1'b0, 32'd0, 1'b0);
    frame(1, 2'b10, 32'h123, -1, 1, 1'b0, 32'd0, 1'b0);
    frame(1, 2'b11, 32'h000, -1, 2, 1'b0, 32'h5A3, 1'b0);
    // reset during SEND, then pending must be clear
    frame(1, 2'b10, 32'h0F0, -1, 1, 1'b0, 32'd0, 1'b0);
    frame(1, 2'b11, 32'h000, -1, 1, 1'b0, 32'hFFF, 1'b1);
    frame(1, 2'b11, 32'h000, -1, 1, 1'b0, 32'hFFF, 1'b0);

    // randomized traffic on both DUTs
    for (int n = 0; n < 50; n++) begin
      int d;
      int ab;
      d  = int'($urandom_range(0, 1));
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, wid[d] + 1)) : -1;
      frame(d, 2'($urandom_range(0, 3)), $urandom, ab, int'($urandom_range(1, 4)),
            1'($urandom_range(0, 1)), $urandom, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("rx_queue_empty", 34'(exp_rx.size()), 34'd0);
    chk("err_queue_empty", 34'(exp_err.size()), 34'd0);
    chk("tx_queue_empty", 34'(exp_tx.size()), 34'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
